// File: rtl/mips_lsu_avalon.sv
// Load/store unit bridging the MIPS core memory port to an Avalon-MM master.
// One request in flight; lane select, extension, LWL/LWR merge and optional bus timeout.
module mips_lsu_avalon #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [31:0]           req_rt_old,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_W-1:0]     address,
    output logic                  read,
    output logic                  write,
    input  logic                  waitrequest,
    output logic [DATA_W-1:0]     writedata,
    output logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     readdata
);

    localparam int NB     = DATA_W / 8;
    localparam int NL     = NB / 4;
    localparam int OFF_W  = $clog2(NB);
    localparam int LANE_W = (NL > 1) ? $clog2(NL) : 1;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t              state, next_state;
    logic [3:0]          op_q;
    logic [1:0]          off_q;
    logic [LANE_W-1:0]   lane_q;
    logic [31:0]         rt_q;
    logic [CNT_W-1:0]    tmo_cnt;

    logic [1:0]          req_off;
    logic [LANE_W-1:0]   req_lane;
    logic [LANE_W+1:0]   req_byte;
    logic                req_illegal, req_misaligned;
    logic [DATA_W-1:0]   st_wdata;
    logic [NB-1:0]       st_be;
    logic                accept_ok, accept_err, bus_done, bus_tmo;
    logic [31:0]         word, load_result;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;
    logic [2:0]          off_p1;

    assign req_off   = req_addr[1:0];
    assign req_byte  = {req_lane, req_off};
    assign req_ready = (state == IDLE);

    generate
        if (NL > 1) begin : g_lane
            assign req_lane = req_addr[OFF_W-1:2];
        end else begin : g_nolane
            assign req_lane = '0;
        end
    endgenerate

    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        case (req_op)
            OP_LB, OP_LBU, OP_LWL, OP_LWR, OP_SB: ;
            OP_LH, OP_LHU, OP_SH:                 req_misaligned = req_off[0];
            OP_LW, OP_SW:                         req_misaligned = (req_off != 2'd0);
            default:                              req_illegal    = 1'b1;
        endcase
    end

    // Store data is replicated across the bus so the enabled lanes always carry it.
    always_comb begin
        st_wdata = '0;
        st_be    = '1;
        case (req_op)
            OP_SB: begin
                st_wdata = {NB{req_wdata[7:0]}};
                st_be    = NB'(1) << req_byte;
            end
            OP_SH: begin
                st_wdata = {(NB/2){req_wdata[15:0]}};
                st_be    = NB'(3) << req_byte;
            end
            OP_SW: begin
                st_wdata = {NL{req_wdata}};
                st_be    = NB'(4'hF) << {req_lane, 2'b00};
            end
            default: ;
        endcase
    end

    always_comb begin
        word = readdata[31:0];
        for (int i = 1; i < NL; i++) begin
            if (lane_q == LANE_W'(i)) word = readdata[32*i +: 32];
        end
        byte_v = word[{off_q, 3'b000} +: 8];
        half_v = word[{off_q[1], 4'b0000} +: 16];
        off_p1 = {1'b0, off_q} + 3'd1;
        case (op_q)
            OP_LB:   load_result = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_result = {24'd0, byte_v};
            OP_LH:   load_result = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_result = {16'd0, half_v};
            OP_LWL:  load_result = (word << {~off_q, 3'b000})
                                 | (rt_q & (32'hFFFF_FFFF >> {off_p1, 3'b000}));
            OP_LWR:  load_result = (word >> {off_q, 3'b000})
                                 | (rt_q & ~(32'hFFFF_FFFF >> {off_q, 3'b000}));
            OP_LW:   load_result = word;
            default: load_result = 32'd0;
        endcase
    end

    always_comb begin
        next_state = state;
        accept_ok  = 1'b0;
        accept_err = 1'b0;
        bus_done   = 1'b0;
        bus_tmo    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_illegal || req_misaligned) begin
                        accept_err = 1'b1;
                        next_state = RESP;
                    end else begin
                        accept_ok  = 1'b1;
                        next_state = BUS;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    bus_done   = 1'b1;
                    next_state = RESP;
                end else if ((TIMEOUT > 0) && (tmo_cnt == CNT_LAST)) begin
                    bus_tmo    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus fields are latched once at accept so they stay stable across stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= '0;
            off_q      <= '0;
            lane_q     <= '0;
            rt_q       <= '0;
            tmo_cnt    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= next_state;
            resp_valid <= 1'b0;
            if (accept_ok) begin
                op_q       <= req_op;
                off_q      <= req_off;
                lane_q     <= req_lane;
                rt_q       <= req_rt_old;
                tmo_cnt    <= '0;
                address    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                writedata  <= st_wdata;
                byteenable <= st_be;
                read       <= ~req_op[3];
                write      <= req_op[3];
            end
            if ((state == BUS) && waitrequest) tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (bus_done || bus_tmo) begin
                read  <= 1'b0;
                write <= 1'b0;
            end
            if (accept_err || bus_tmo) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
                resp_rdata <= '0;
            end
            if (bus_done) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_rdata <= op_q[3] ? 32'd0 : load_result;
            end
        end
    end

endmodule
